// File: rtl/bin2bcd_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_if;
   logic        start;
   logic [13:0] bin;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [3:0]  d0;
   logic [3:0]  d1;
   logic [3:0]  d2;
   logic [3:0]  d3;

   modport master (
      output start, bin,
      input  busy, done, ovf, d0, d1, d2, d3
   );

   modport slave (
      input  start, bin,
      output busy, done, ovf, d0, d1, d2, d3
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// 14-bit binary to 4-digit BCD, one double-dabble step per clock,
// fixed 15-clock latency with saturation above 9999.
module bin2bcd_seq (
   input  logic      clk,
   input  logic      reset,
   bin2bcd_if.slave  io
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [13:0] sh_q, sh_d;
   logic [19:0] acc_q, acc_d;
   logic [19:0] acc_adj;
   logic [33:0] cat;
   logic [3:0]  cnt_q, cnt_d;
   logic        ovp_q, ovp_d;
   logic [15:0] dig_q, dig_d;
   logic        ovf_q, ovf_d;
   logic        done_q, done_d;

   // Five nibbles so a 14-bit input can never wrap the accumulator.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 5; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      cat = {acc_adj, sh_q} << 1;
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovp_d   = ovp_q;
      dig_d   = dig_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (io.start) begin
               sh_d    = io.bin;
               acc_d   = '0;
               cnt_d   = '0;
               ovp_d   = (io.bin > 14'd9999);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = cat[33:14];
            sh_d  = cat[13:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13)
               state_d = DONE;
         end
         DONE: begin
            dig_d   = ovp_q ? 16'h9999 : acc_q[15:0];
            ovf_d   = ovp_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovp_q   <= 1'b0;
         dig_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovp_q   <= ovp_d;
         dig_q   <= dig_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // The done cycle is still reported busy; the FSM itself is already idle.
   assign io.busy = (state_q != IDLE) | done_q;
   assign io.done = done_q;
   assign io.ovf  = ovf_q;
   assign io.d0   = dig_q[3:0];
   assign io.d1   = dig_q[7:4];
   assign io.d2   = dig_q[11:8];
   assign io.d3   = dig_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits are queued at launch
// and popped when done pulses.
module tb_bin2bcd_seq;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [16:0] sb[$];

   bin2bcd_if io ();

   bin2bcd_seq dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] exp_of(input int b);
      if (b > 9999)
         return {1'b1, 16'h9999};
      return {1'b0, 4'(b / 1000), 4'((b / 100) % 10),
              4'((b / 10) % 10), 4'(b % 10)};
   endfunction

   function automatic logic [16:0] got();
      return {io.ovf, io.d3, io.d2, io.d1, io.d0};
   endfunction

   // Drives one start pulse; returns at the negedge after the accept edge.
   task automatic launch(input int b);
      @(negedge clk);
      io.bin   = 14'(b);
      io.start = 1'b1;
      sb.push_back(exp_of(b));
      @(negedge clk);
      io.start = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      io.start = 1'b0;
      io.bin   = '0;
      #3;
      n_tests++;
      if ({io.busy, io.done, got()} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=0",
                  {io.busy, io.done, got()});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_values;
      int vals[10];
      int lat;
      bit found;
      bit busy_bad;
      logic [16:0] e;
      vals = '{0, 1234, 9999, 10000, 16383, 7, 8000, 0, 0, 0};
      for (int i = 7; i < 10; i++)
         vals[i] = int'($urandom_range(0, 16383));
      for (int i = 0; i < 10; i++) begin
         launch(vals[i]);
         busy_bad = !io.busy;
         lat = 0;
         found = 1'b0;
         while (!found && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!io.busy) busy_bad = 1'b1;
            if (io.done) found = 1'b1;
         end
         e = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
         n_tests++;
         if (!found || lat != 15) begin
            n_fail++;
            $display("FAIL latency bin=%0d got=%0d exp=15", vals[i], lat);
         end
         n_tests++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL digits bin=%0d got=%h exp=%h", vals[i], got(), e);
         end
         n_tests++;
         if (busy_bad) begin
            n_fail++;
            $display("FAIL busy_window bin=%0d got=low exp=high", vals[i]);
         end
         @(negedge clk);
         n_tests++;
         if (io.done !== 1'b0 || io.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done bin=%0d got done=%b busy=%b exp=0,0",
                     vals[i], io.done, io.busy);
         end
         // Results must hold while bin wanders with start low.
         io.bin = 14'($urandom);
         repeat (4) @(negedge clk);
         n_tests++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL hold bin=%0d got=%h exp=%h", vals[i], got(), e);
         end
      end
   endtask

   task automatic test_ignore_start;
      int pulses;
      int at;
      logic [16:0] e;
      pulses = 0;
      at = -1;
      e = 17'h1ffff;
      launch(42);
      repeat (4) @(negedge clk);
      io.start = 1'b1;
      io.bin   = 14'd777;
      @(negedge clk);
      io.start = 1'b0;
      for (int c = 6; c <= 30; c++) begin
         @(negedge clk);
         if (io.done) begin
            pulses++;
            if (at < 0) begin
               at = c;
               e = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
               n_tests++;
               if (got() !== e) begin
                  n_fail++;
                  $display("FAIL busy_start_digits got=%h exp=%h", got(), e);
               end
            end
         end
      end
      n_tests++;
      if (pulses != 1 || at != 15) begin
         n_fail++;
         $display("FAIL busy_start_pulses got=%0d@%0d exp=1@15", pulses, at);
      end
   endtask

   task automatic test_abort;
      int pulses;
      int lat;
      bit found;
      logic [16:0] e;
      pulses = 0;
      launch(5678);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      void'(sb.pop_back());
      n_tests++;
      if ({io.busy, io.done, got()} !== 19'd0) begin
         n_fail++;
         $display("FAIL abort_clear got=%h exp=0", {io.busy, io.done, got()});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (io.done || got() !== 17'd0) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_quiet got=%0d exp=0", pulses);
      end
      launch(321);
      lat = 0;
      found = 1'b0;
      while (!found && lat < 20) begin
         @(negedge clk);
         lat++;
         if (io.done) found = 1'b1;
      end
      e = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
      n_tests++;
      if (!found || lat != 15 || got() !== e) begin
         n_fail++;
         $display("FAIL post_reset got=%h@%0d exp=%h@15", got(), lat, e);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      logic [16:0] e;
      pulses = 0;
      @(negedge clk);
      io.bin   = 14'd305;
      io.start = 1'b1;
      for (int k = 0; k < 3; k++)
         sb.push_back(exp_of(305));
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (io.done) begin
            pulses++;
            e = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
            n_tests++;
            if (c != 15 + 16 * (pulses - 1) || got() !== e) begin
               n_fail++;
               $display("FAIL back_to_back got=%h@%0d exp=%h@%0d",
                        got(), c, e, 15 + 16 * (pulses - 1));
            end
         end
      end
      io.start = 1'b0;
      n_tests++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL back_to_back_count got=%0d exp=3", pulses);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_values();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
